// File: rtl/dispatch_queue.sv
// In-order multi-lane dispatch buffer between decode and issue, with flush and sticky error.
// Enqueued entries are visible one cycle later; enq_ready drops when fewer than ENQ_W slots are free.
module dispatch_queue #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8,
    parameter int ENQ_W  = 2,
    parameter int DEQ_W  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [$clog2(ENQ_W+1)-1:0]   enq_cnt,
    input  logic [ENQ_W*DATA_W-1:0]      enq_data,
    output logic                         enq_ready,
    output logic [DEQ_W*DATA_W-1:0]      deq_data,
    output logic [DEQ_W-1:0]             deq_valid,
    input  logic [$clog2(DEQ_W+1)-1:0]   deq_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int EC_W  = $clog2(ENQ_W+1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic              enq_ok;
    logic              deq_ok;
    logic [CNT_W-1:0]  enq_acc;
    logic [CNT_W-1:0]  deq_acc;

    assign enq_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(ENQ_W);
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);

    assign enq_ok  = (enq_cnt != '0) && enq_ready;
    assign deq_ok  = (CNT_W'(deq_cnt) <= count);
    assign enq_acc = enq_ok ? CNT_W'(enq_cnt) : '0;
    assign deq_acc = deq_ok ? CNT_W'(deq_cnt) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            err   <= 1'b0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if ((enq_cnt != '0) && !enq_ready) begin
                err <= 1'b1;
            end
            if (!deq_ok) begin
                err <= 1'b1;
            end
            head  <= head + PTR_W'(deq_acc);
            tail  <= tail + PTR_W'(enq_acc);
            count <= count + enq_acc - deq_acc;
        end
    end

    // Storage needs no reset; only slots between head and tail are ever presented.
    always_ff @(posedge clk) begin
        if (!rst && !flush && enq_ok) begin
            for (int i = 0; i < ENQ_W; i++) begin
                if (EC_W'(i) < enq_cnt) begin
                    mem[tail + PTR_W'(i)] <= enq_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        deq_data  = '0;
        deq_valid = '0;
        for (int i = 0; i < DEQ_W; i++) begin
            deq_valid[i] = (count > CNT_W'(i));
            if (deq_valid[i]) begin
                deq_data[i*DATA_W +: DATA_W] = mem[head + PTR_W'(i)];
            end
        end
    end

endmodule

// File: doc/dispatch_queue.md
Name: dispatch_queue

Overview:
Parametrised multi-wide in-order dispatch buffer, successor to the single-entry-per-cycle dispatch FIFO. It sits between decode and issue. Each cycle it accepts up to ENQ_W decoded instructions and presents up to DEQ_W oldest instructions to issue. It adds flush for branch mispredict/exception recovery, an occupancy count and a sticky protocol-error flag.

Parameters:
DATA_W, 64, bits per decoded instruction entry
DEPTH, 8, number of entries; power of 2, >= max(ENQ_W, DEQ_W)
ENQ_W, 2, max instructions enqueued per cycle
DEQ_W, 2, max instructions dequeued per cycle

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, synchronous, active-high (one clock; reset is synchronous and active-high)
flush  in  1  discard all entries this edge
enq_cnt  in  $clog2(ENQ_W+1)  number of lanes to enqueue (lanes 0..enq_cnt-1)
enq_data  in  ENQ_W*DATA_W  lane i at [i*DATA_W +: DATA_W]; lane 0 oldest
enq_ready  out  1  high when free slots >= ENQ_W
deq_data  out  DEQ_W*DATA_W  lane i = i-th oldest entry; 0 when lane invalid
deq_valid  out  DEQ_W  thermometer: bit i high iff count > i
deq_cnt  in  $clog2(DEQ_W+1)  number of lanes issue consumes this edge
count  out  $clog2(DEPTH+1)  current occupancy
full  out  1  count == DEPTH
empty  out  1  count == 0
err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (rst=1 at edge): head=tail=0, count=0, err=0. Outputs after reset: empty=1, full=0, enq_ready=1, deq_valid=0, deq_data=0. Storage contents are don't-care. Reset overrides flush/enq/deq, including mid-operation.
- All status outputs derive from registered state. deq_data/deq_valid are combinational reads of storage at head..head+DEQ_W-1 (mod DEPTH). Enqueue-to-visible latency is 1 cycle; there is no same-cycle bypass.
- enq_ready = (DEPTH - count) >= ENQ_W, from the registered count. A same-cycle dequeue does not raise it.
- Enqueue: if enq_cnt>0 and enq_ready, write lanes 0..enq_cnt-1 to tail..tail+enq_cnt-1 mod DEPTH, and tail += enq_cnt. If enq_cnt>0 and !enq_ready, write nothing and set err.
- Dequeue: if deq_cnt <= count, head += deq_cnt mod DEPTH. If deq_cnt > count, nothing is dequeued and err is set. Enqueue in the same cycle still proceeds on its own rule.
- Next count = count + accepted_enq - accepted_deq. Simultaneous enq/deq is allowed at any occupancy that satisfies the rules above, including full with deq only, and empty with enq only.
- Pointers are $clog2(DEPTH) bits with natural wrap; multi-lane writes/reads that straddle the wrap must preserve order.
- Flush (rst=0): head=tail=0, count=0, and any same-cycle enq/deq is discarded. err is not cleared and no new err is raised that cycle.
- err is cleared only by rst.
- Order is strictly FIFO across lanes and cycles.

Test Plan:
- Reset: rst=1 for 1 edge -> count=0, empty=1, full=0, enq_ready=1, deq_valid=2'b00, deq_data=0, err=0.
- Fill: enq_cnt=2 for 4 cycles with data 0x10..0x17, deq_cnt=0 -> count 2,4,6,8. After the 3rd edge (count=6) enq_ready=1; after the 4th, full=1 and enq_ready=0. deq_valid=2'b11, lane0=0x10, lane1=0x11.
- Overflow: at count=8, enq_cnt=1 -> count stays 8, err=1, lane0 still 0x10. Then deq_cnt=2 -> count=6, lane0=0x12, err stays 1.
- Wrap + simultaneous: from count=4 with head=6, enq_cnt=2 (0xA0,0xA1) and deq_cnt=2 each cycle for 4 cycles -> count stays 4, entries exit in exact enqueue order across index 7->0.
- Underflow: count=1, deq_cnt=2 -> count=1, deq_valid=2'b01, lane1 data=0, err=1. Same cycle enq_cnt=1 accepted -> count=2.
- Flush/reset priority: count=5, flush=1 with enq_cnt=2, deq_cnt=1 -> count=0, empty=1, err unchanged. Then rst=1 with enq_cnt=2 -> count=0, err=0.
